// File: rtl/conv3x3_mac_p_if.sv
// Window-stream, coefficient-port and result-stream bundle for conv3x3_mac_p.
interface conv3x3_mac_p_if #(
  parameter int P    = 4,
  parameter int BITW = 8,
  parameter int CW   = 8
);
  // Valid-only streams: a lane carries data when its valid bit is 1 in a cycle;
  // there is no ready, the consumer must accept one P-lane vector every cycle.
  logic [P-1:0]      win_valid_vec;
  logic [P*BITW-1:0] w00, w01, w02;
  logic [P*BITW-1:0] w10, w11, w12;
  logic [P*BITW-1:0] w20, w21, w22;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [CW-1:0]     coef_data;
  logic              coef_commit;
  logic [P-1:0]      out_valid_vec;
  logic [P*BITW-1:0] out_pix_vec;
  logic [P-1:0]      out_sat_vec;

  modport master (
    output win_valid_vec, w00, w01, w02, w10, w11, w12, w20, w21, w22,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid_vec, out_pix_vec, out_sat_vec
  );

  modport slave (
    input  win_valid_vec, w00, w01, w02, w10, w11, w12, w20, w21, w22,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output out_valid_vec, out_pix_vec, out_sat_vec
  );
endinterface

// File: rtl/conv3x3_mac_p.sv
// P-lane 3x3 convolution: S1 products, S2 row sums, S3 round/shift/clamp; double-buffered kernel.
// Optional CONV_ABS_EN: take |sum| before rounding (edge magnitude), so only the high clamp can fire.
module conv3x3_mac_p #(
  parameter int P     = 4,
  parameter int BITW  = 8,
  parameter int CW    = 8,
  parameter int SHIFT = 4
) (
  input  logic           clk,
  input  logic           rst,
  conv3x3_mac_p_if.slave bus
);
  localparam int PW = BITW + CW + 1;
  localparam int SW = PW + 4;
  localparam logic signed [SW:0]   RND     = (SW+1)'((2 ** SHIFT) / 2);
  localparam logic signed [SW:0]   PIX_MAX = (SW+1)'((2 ** BITW) - 1);
  localparam logic signed [CW-1:0] K_ONE   = CW'(2 ** SHIFT);

  logic signed [CW-1:0] shadow_q [9];
  logic signed [CW-1:0] active_q [9];

  // Commit samples the pre-edge shadow, so a same-cycle write only lands in shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= (k == 4) ? K_ONE : '0;
        active_q[k] <= (k == 4) ? K_ONE : '0;
      end
    end else begin
      if (bus.coef_commit) begin
        for (int k = 0; k < 9; k++) active_q[k] <= shadow_q[k];
      end
      if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
        shadow_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end

  logic [BITW-1:0] pix [P][9];

  for (genvar l = 0; l < P; l++) begin : g_win
    assign pix[l][0] = bus.w00[l*BITW +: BITW];
    assign pix[l][1] = bus.w01[l*BITW +: BITW];
    assign pix[l][2] = bus.w02[l*BITW +: BITW];
    assign pix[l][3] = bus.w10[l*BITW +: BITW];
    assign pix[l][4] = bus.w11[l*BITW +: BITW];
    assign pix[l][5] = bus.w12[l*BITW +: BITW];
    assign pix[l][6] = bus.w20[l*BITW +: BITW];
    assign pix[l][7] = bus.w21[l*BITW +: BITW];
    assign pix[l][8] = bus.w22[l*BITW +: BITW];
  end

  logic signed [PW-1:0] prod_d [P][9];
  logic signed [PW-1:0] prod_q [P][9];
  logic signed [SW-1:0] row_d  [P][3];
  logic signed [SW-1:0] row_q  [P][3];
  logic [P-1:0]         v1_q, v2_q, valid_q, sat_q;
  logic [P*BITW-1:0]    pix_q;
  logic [BITW-1:0]      res_d [P];
  logic                 sat_d [P];

  // Pixels are zero-extended so the product stays signed without losing the MSB.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      for (int k = 0; k < 9; k++) begin
        prod_d[l][k] = PW'($signed({1'b0, pix[l][k]})) * PW'(active_q[k]);
      end
      for (int r = 0; r < 3; r++) begin
        row_d[l][r] = SW'(prod_q[l][3*r]) + SW'(prod_q[l][3*r+1]) + SW'(prod_q[l][3*r+2]);
      end
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_out
    logic signed [SW:0] sum, mag, shifted;

    always_comb begin
      sum = (SW+1)'(row_q[l][0]) + (SW+1)'(row_q[l][1]) + (SW+1)'(row_q[l][2]);
`ifdef CONV_ABS_EN
      mag = (sum < 0) ? -sum : sum;
`else
      mag = sum;
`endif
      shifted  = (mag + RND) >>> SHIFT;
      res_d[l] = shifted[BITW-1:0];
      sat_d[l] = 1'b0;
      if (shifted < 0) begin
        res_d[l] = '0;
        sat_d[l] = 1'b1;
      end else if (shifted > PIX_MAX) begin
        res_d[l] = '1;
        sat_d[l] = 1'b1;
      end
      // Invalid lanes still flow through but present a clean zero.
      if (!v2_q[l]) begin
        res_d[l] = '0;
        sat_d[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= '0;
      v2_q    <= '0;
      valid_q <= '0;
      sat_q   <= '0;
      pix_q   <= '0;
      for (int l = 0; l < P; l++) begin
        for (int k = 0; k < 9; k++) prod_q[l][k] <= '0;
        for (int r = 0; r < 3; r++) row_q[l][r] <= '0;
      end
    end else begin
      v1_q    <= bus.win_valid_vec;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      for (int l = 0; l < P; l++) begin
        for (int k = 0; k < 9; k++) prod_q[l][k] <= prod_d[l][k];
        for (int r = 0; r < 3; r++) row_q[l][r] <= row_d[l][r];
        pix_q[l*BITW +: BITW] <= res_d[l];
        sat_q[l]              <= sat_d[l];
      end
    end
  end

  assign bus.out_valid_vec = valid_q;
  assign bus.out_pix_vec   = pix_q;
  assign bus.out_sat_vec   = sat_q;
endmodule
